// File: rtl/pipeline_ctrl.sv
// Stage sequencer for the 5-stage MIPS pipeline: per-stage reset/enable generation
// from load-use stalls and BEQ resolution, plus post-reset flush, single-step and perf counters.
module pipeline_ctrl #(
  parameter int unsigned RST_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_stall,
  input  logic        id_valid,
  input  logic        is_branch_ctrl,
  input  logic        br_taken_mem,
  input  logic        debug_mode,
  input  logic        debug_step,
  output logic        if_rst,
  output logic        id_rst,
  output logic        exe_rst,
  output logic        mem_rst,
  output logic        wb_rst,
  output logic        if_en,
  output logic        id_en,
  output logic        exe_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic [31:0] cycle_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int unsigned CW = 32;
  localparam int unsigned IW = 8;
  localparam int unsigned NS = 5;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_BR_EXE, S_BR_MEM} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic          step_q, step_d;
  logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;

  logic          adv_c, stall_c, branch_c;
  logic [NS-1:0] rst_v_c, en_raw_c, en_v_c;

  // A held debug_step only advances on its rising edge
  assign adv_c    = ~debug_mode | (debug_step & ~step_q);
  assign stall_c  = reg_stall & id_valid;
  assign branch_c = is_branch_ctrl & id_valid & ~stall_c;
  assign step_d   = debug_step;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      init_cnt_q <= IW'(RST_CYCLES - 1);
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      step_q     <= step_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (adv_c) begin
      case (state_q)
        S_INIT: begin
          if (init_cnt_q == IW'(0)) state_d = S_RUN;
          else                      init_cnt_d = init_cnt_q - IW'(1);
        end
        S_RUN:    if (branch_c) state_d = S_BR_EXE;
        S_BR_EXE: state_d = S_BR_MEM;
        S_BR_MEM: state_d = S_RUN;
        default:  state_d = S_INIT;
      endcase
    end
  end

  // Stage controls, order {if, id, exe, mem, wb}
  always_comb begin
    rst_v_c  = '0;
    en_raw_c = '0;
    if (rst) begin
      rst_v_c = '1;
    end else if (adv_c) begin
      case (state_q)
        S_INIT: rst_v_c = '1;
        S_RUN: begin
          if (stall_c) begin
            rst_v_c  = 5'b00100;
            en_raw_c = 5'b00011;
          end else if (branch_c) begin
            rst_v_c  = 5'b01000;
            en_raw_c = 5'b01111;
          end else begin
            en_raw_c = 5'b11111;
          end
        end
        S_BR_EXE: begin
          rst_v_c  = 5'b01000;
          en_raw_c = 5'b00111;
        end
        S_BR_MEM: begin
          rst_v_c  = 5'b01000;
          en_raw_c = {br_taken_mem, 4'b0111};
        end
        default: rst_v_c = '1;
      endcase
    end
  end

  assign en_v_c = en_raw_c & ~rst_v_c;

  // Performance counters
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (adv_c && (state_q != S_INIT)) cycle_cnt_d = cycle_cnt_q + CW'(1);
    if (adv_c && (state_q == S_RUN) && stall_c)  stall_cnt_d = stall_cnt_q + CW'(1);
    if (adv_c && (state_q == S_RUN) && branch_c) flush_cnt_d = flush_cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = rst_v_c;
  assign {if_en, id_en, exe_en, mem_en, wb_en}      = en_v_c;
  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed per-cycle vectors push expectations,
// a negedge monitor pops and compares stage controls and counters.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst, reg_stall, id_valid, is_branch_ctrl, br_taken_mem, debug_mode, debug_step;
  logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic        if_en, id_en, exe_en, mem_en, wb_en;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

  typedef struct {
    int          idx;
    logic [4:0]  rsts;
    logic [4:0]  ens;
    logic [31:0] cc;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.RST_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .reg_stall(reg_stall), .id_valid(id_valid),
    .is_branch_ctrl(is_branch_ctrl), .br_taken_mem(br_taken_mem),
    .debug_mode(debug_mode), .debug_step(debug_step),
    .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
    .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, req);
    end
  endtask

  // Monitor: the DUT presents stage controls every cycle; compare mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stage_rst", e.idx, 32'({if_rst, id_rst, exe_rst, mem_rst, wb_rst}), 32'(e.rsts));
      chk("stage_en",  e.idx, 32'({if_en, id_en, exe_en, mem_en, wb_en}), 32'(e.ens));
      chk("cycle_cnt", e.idx, cycle_cnt, e.cc);
      chk("stall_cnt", e.idx, stall_cnt, e.sc);
      chk("flush_cnt", e.idx, flush_cnt, e.fc);
    end
  end

  // One cycle: inputs {rst, reg_stall, id_valid, is_branch, br_taken, debug_mode, debug_step}
  task automatic cyc(input logic r, input logic rs, input logic iv, input logic br,
                     input logic bt, input logic dm, input logic ds,
                     input logic [4:0] e_rst, input logic [4:0] e_en,
                     input int unsigned e_cc, input int unsigned e_sc, input int unsigned e_fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; reg_stall = rs; id_valid = iv; is_branch_ctrl = br;
    br_taken_mem = bt; debug_mode = dm; debug_step = ds;
    vec++;
    e.idx = vec; e.rsts = e_rst; e.ens = e_en;
    e.cc = 32'(e_cc); e.sc = 32'(e_sc); e.fc = 32'(e_fc);
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; reg_stall = 1'b0; id_valid = 1'b0; is_branch_ctrl = 1'b0;
    br_taken_mem = 1'b0; debug_mode = 1'b0; debug_step = 1'b0;

    // Reset held two cycles, then five INIT cycles
    cyc(1,0,0,0,0,0,0, 5'b11111, 5'b00000, 0,0,0);
    cyc(1,0,0,0,0,0,0, 5'b11111, 5'b00000, 0,0,0);
    for (int i = 0; i < 5; i++)
      cyc(0,0,0,0,0,0,0, 5'b11111, 5'b00000, 0,0,0);
    cyc(0,0,1,0,0,0,0, 5'b00000, 5'b11111, 0,0,0);

    // Load-use stall two cycles, then reg_stall without id_valid is ignored
    cyc(0,1,1,0,0,0,0, 5'b00100, 5'b00011, 1,0,0);
    cyc(0,1,1,0,0,0,0, 5'b00100, 5'b00011, 2,1,0);
    cyc(0,0,1,0,0,0,0, 5'b00000, 5'b11111, 3,2,0);
    cyc(0,1,0,0,0,0,0, 5'b00000, 5'b11111, 4,2,0);

    // BEQ taken; stall request in BR_EXE must be ignored
    cyc(0,0,1,1,0,0,0, 5'b01000, 5'b00111, 5,2,0);
    cyc(0,1,1,0,0,0,0, 5'b01000, 5'b00111, 6,2,1);
    cyc(0,0,0,0,1,0,0, 5'b01000, 5'b10111, 7,2,1);
    cyc(0,0,1,0,0,0,0, 5'b00000, 5'b11111, 8,2,1);

    // BEQ not taken
    cyc(0,0,1,1,0,0,0, 5'b01000, 5'b00111, 9,2,1);
    cyc(0,0,0,0,0,0,0, 5'b01000, 5'b00111, 10,2,2);
    cyc(0,0,0,0,0,0,0, 5'b01000, 5'b00111, 11,2,2);
    cyc(0,0,1,0,0,0,0, 5'b00000, 5'b11111, 12,2,2);

    // Stall wins over a simultaneous branch
    cyc(0,1,1,1,0,0,0, 5'b00100, 5'b00011, 13,2,2);
    cyc(0,0,1,0,0,0,0, 5'b00000, 5'b11111, 14,3,2);

    // Single-step: held step advances exactly once
    cyc(0,0,1,0,0,1,0, 5'b00000, 5'b00000, 15,3,2);
    cyc(0,0,1,0,0,1,1, 5'b00000, 5'b11111, 15,3,2);
    cyc(0,0,1,0,0,1,1, 5'b00000, 5'b00000, 16,3,2);
    cyc(0,0,1,0,0,1,1, 5'b00000, 5'b00000, 16,3,2);
    cyc(0,0,1,0,0,1,1, 5'b00000, 5'b00000, 16,3,2);
    cyc(0,0,1,0,0,1,0, 5'b00000, 5'b00000, 16,3,2);
    cyc(0,0,1,0,0,0,0, 5'b00000, 5'b11111, 16,3,2);
    cyc(0,0,1,0,0,0,0, 5'b00000, 5'b11111, 17,3,2);

    // Reset during BR_EXE clears everything, INIT then RUN again
    cyc(0,0,1,1,0,0,0, 5'b01000, 5'b00111, 18,3,2);
    cyc(1,0,0,0,0,0,0, 5'b11111, 5'b00000, 19,3,3);
    for (int i = 0; i < 5; i++)
      cyc(0,0,0,0,0,0,0, 5'b11111, 5'b00000, 0,0,0);
    cyc(0,0,1,0,0,0,0, 5'b00000, 5'b11111, 0,0,0);
    cyc(0,0,1,0,0,0,0, 5'b00000, 5'b11111, 1,0,0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Stage sequencer for the 5-stage pipelined MIPS core. Drives the per-stage reset/enable pairs (IF, ID, EXE, MEM, WB) of the datapath from its load-use stall request and BEQ resolution, with no forwarding. Provides a post-reset flush sequence, a debug single-step mode and 32-bit performance counters. Sits beside the control unit at CPU top level.

## Interface
- RST_CYCLES, default 5: cycles all stage resets stay asserted after `rst` deasserts (1..255).
- clk  in  1  main clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- reg_stall  in  1  datapath hazard request (RS/RT of ID instruction pending in EXE or MEM).
- id_valid  in  1  ID stage holds a valid instruction.
- is_branch_ctrl  in  1  decoder: ID instruction is BEQ.
- br_taken_mem  in  1  BEQ in MEM resolved taken (datapath `is_branch_mem`).
- debug_mode  in  1  1 = single-step mode; 0 = free run.
- debug_step  in  1  step request, level input; rising edge advances one cycle.
- if_rst, id_rst, exe_rst, mem_rst, wb_rst  out  1 each  stage resets.
- if_en, id_en, exe_en, mem_en, wb_en  out  1 each  stage enables.
- cycle_cnt  out  32  advanced cycles since end of INIT.
- stall_cnt  out  32  cycles with a load-use bubble inserted.
- flush_cnt  out  32  BEQ instructions accepted from ID.

## Operation
- FSM states: INIT, RUN, BR_EXE, BR_MEM. Registered: state, 8-bit init counter, step_q (debug_step delayed), counters.
- adv = ~debug_mode | (debug_step & ~step_q). adv=0: all `*_en`=0, all `*_rst`=0, state/counters hold.
- stall = reg_stall & id_valid. branch = is_branch_ctrl & id_valid & ~stall.
- INIT: all `*_rst`=1, all `*_en`=0; counter decrements on adv; at 0 -> RUN.
- RUN, stall: if_en=0, id_en=0, exe_rst=1 (bubble), mem_en=wb_en=1; stay RUN; stall_cnt+1.
- RUN, branch: all en=1 except if_en=0 (PC held at branch+4); id_rst=1 (squash fetch); -> BR_EXE; flush_cnt+1.
- RUN, neither: all `*_en`=1, no resets.
- BR_EXE: if_en=0, id_rst=1, exe/mem/wb en=1; -> BR_MEM.
- BR_MEM: if_en=br_taken_mem (taken loads target, not-taken keeps branch+4), id_rst=1, exe/mem/wb en=1; -> RUN.
- Any `*_rst`=1 forces the same stage's `*_en`=0. Stall is ignored in BR_EXE/BR_MEM (ID is a bubble, id_valid=0).
- cycle_cnt +1 per adv cycle outside INIT. All counters wrap 0xFFFF_FFFF -> 0.

## Timing
- Stage controls combinational from registered state and current inputs (same-cycle reaction to reg_stall).
- rst=1 (any time, including mid-branch or mid-step): same cycle all `*_rst`=1, all `*_en`=0; next edge state=INIT, init counter=RST_CYCLES-1, step_q=0, counters=0.
- INIT lasts exactly RST_CYCLES adv cycles after rst falls; first RUN cycle then.
- BEQ penalty: 3 cycles (accept, BR_EXE, BR_MEM) with no new fetch into ID; first post-branch instruction enters ID in the cycle after BR_MEM.
- Load-use: bubble repeats every cycle reg_stall & id_valid holds; no limit.
- debug_mode 1->0 mid-sequence: FSM resumes from held state next cycle. Held debug_step advances once only.
- step_q updates every cycle regardless of adv.

## Test plan
- Reset, RST_CYCLES=5: rst high 2 cycles, release -> all `*_rst`=1 for 5 cycles, then all `*_en`=1, `*_rst`=0; counters 0.
- Load-use: reg_stall=1, id_valid=1 for 2 RUN cycles -> if_en=id_en=0, exe_rst=1 both cycles, stall_cnt=2; then normal.
- BEQ taken: is_branch_ctrl=1 in RUN, br_taken_mem=1 in BR_MEM -> if_en 0,0,1; id_rst 1,1,1; back in RUN; flush_cnt=1.
- BEQ not taken: same with br_taken_mem=0 -> if_en 0,0,0 over 3 cycles, then RUN with if_en=1.
- Debug: debug_mode=1, debug_step high 4 cycles then low -> exactly one cycle with enables set; cycle_cnt +1.
- rst during BR_EXE -> same cycle all resets asserted; after release INIT then RUN, flush_cnt=0.
